prog_automata: RTL and testbench
================================

// Module: prog_automata
// PURPOSE
// Table-driven Mealy automaton engine. Replaces hand-coded lab FSMs (fixed states, fixed U/C widths).
// Each state holds up to RULES prioritised product-term rules over input U; the first match selects next state and registered output C.
// The transition table is written at runtime through a config port while the engine is halted.
// Any lab FSM becomes a table load instead of new RTL.
// PARAMETERS
// U_W          8   input vector width
// C_W          8   output vector width
// N_STATES     8   number of states (>=2); SW = $clog2(N_STATES)
// RULES        4   rules per state (>=2); RW = $clog2(RULES)
// RESET_STATE  0   state entered on rst (< N_STATES)
// PORTS
// clk        in   1     clock
// rst        in   1     reset, synchronous, active-high
// run        in   1     1: step every cycle; 0: halt (state and C frozen), table writable
// U          in   U_W   condition inputs, sampled at posedge
// C          out  C_W   registered output word
// state      out  SW    current state register
// hit        out  1     registered: last step matched a rule
// hit_rule   out  RW    registered: index of matched rule (valid when hit=1)
// cfg_we     in   1     table write strobe
// cfg_dflt   in   1     0: write rule entry; 1: write state default entry
// cfg_state  in   SW    target state index
// cfg_rule   in   RW    target rule index (ignored when cfg_dflt=1)
// cfg_en     in   1     rule enable / default-output enable
// cfg_mask   in   U_W   care mask of product term
// cfg_value  in   U_W   required values of cared bits
// cfg_next   in   SW    next state for rule
// cfg_out    in   C_W   C value for rule / default
// cfg_err    out  1     registered one-cycle pulse: write rejected
// BEHAVIOUR
// - Reset: state=RESET_STATE, C=0, hit=0, hit_rule=0, cfg_err=0; all rules en=0; all defaults en=1, out=0. Reset wins over run and cfg_we.
// - Rule r of state s matches when en && ((U & mask) == (value & mask)); mask=0 with en=1 always matches.
// - Step (run=1): lowest-index matching rule wins. Next cycle: state<=next, C<=out, hit<=1, hit_rule<=r.
// - No match: state holds, hit<=0, hit_rule holds. C<=dflt_out if dflt_en; otherwise C holds.
// - Latency: U at edge k -> state/C/hit visible after edge k (one register stage, no combinational U->C path).
// - Halt (run=0): state, C, hit, hit_rule hold; no rule evaluation.
// - Config write is accepted only when run=0 and cfg_state<N_STATES and (cfg_dflt || cfg_next<N_STATES). Written data is effective from the next cycle.
// - Rejected write (run=1 or an out-of-range index): table unchanged, cfg_err=1 for one cycle. cfg_err=0 on every other cycle.
// - Simultaneous run=1 and cfg_we: the step proceeds normally and the write is rejected.
// - State register can never hold a value >= N_STATES: the write check guarantees it, and RESET_STATE is range-checked by an elaboration assertion.
// STRUCTURE
// - Package automata_pkg: rule_t struct {en, mask, value, next, out}, dflt_t struct {en, out}, and width helper functions.
// - Sub-module automata_rule_match: combinational priority matcher over one state's RULES entries; outputs any_hit and rule index.
// - Top: table registers, state/C/hit registers, config decode/check, and a mux selecting the current state's rule row.
// TESTING
// - Load s0 r0 {mask=03,value=00,next=2,out=83}; run, U=FC -> next cycle state=2, C=83, hit=1, hit_rule=0.
// - s2 r0 {mask=08,value=08,next=2,out=84} and r1 {mask=00,next=1,out=F5}; U=08 -> hit_rule=0, state=2, C=84. U=00 -> hit_rule=1, state=1, C=F5.
// - No match in s1 with dflt {en=1,out=00} -> C=00, state=1, hit=0. Same case with dflt en=0 and prior C=F5 -> C stays F5.
// - cfg_we while run=1 -> cfg_err=1 for exactly one cycle, table unchanged. cfg_next=N_STATES with run=0 -> cfg_err=1, no write.
// - run=0 for 5 cycles with U toggling -> state, C, hit constant. Valid write then accepted with cfg_err=0.
// - rst mid-sequence (state=3, C=AE) -> next cycle state=RESET_STATE, C=00, all rules disabled, default C=00 on every later step.

Source files
------------

// File: rtl/automata_pkg.sv
// Shared types and width helpers for the table-driven automaton engine.
// rule_t/dflt_t are sized by the package widths; the top checks its parameters against them.
package automata_pkg;

  localparam int PKG_U_W      = 8;
  localparam int PKG_C_W      = 8;
  localparam int PKG_N_STATES = 8;
  localparam int PKG_RULES    = 4;

  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic in_range(input int unsigned v, input int unsigned n);
    return v < n;
  endfunction

  localparam int PKG_SW = width_of(PKG_N_STATES);

  typedef struct packed {
    logic               en;
    logic [PKG_U_W-1:0] mask;
    logic [PKG_U_W-1:0] value;
    logic [PKG_SW-1:0]  next;
    logic [PKG_C_W-1:0] out;
  } rule_t;

  typedef struct packed {
    logic               en;
    logic [PKG_C_W-1:0] out;
  } dflt_t;

endpackage

// File: rtl/automata_rule_match.sv
// Combinational priority matcher over one state's rule row; lowest matching index wins.
// Also muxes out the winning rule so the top sees next/out without a second index.
module automata_rule_match
  import automata_pkg::*;
#(
  parameter int RULES = PKG_RULES,
  parameter int RW    = width_of(RULES)
) (
  input  logic [PKG_U_W-1:0] i_u,
  input  rule_t              i_row [RULES],
  output logic               o_any_hit,
  output logic [RW-1:0]      o_rule,
  output rule_t              o_sel
);

  always_comb begin
    o_any_hit = 1'b0;
    o_rule    = '0;
    o_sel     = '0;
    // Scan high to low so the lowest matching index is the last assignment.
    for (int r = RULES - 1; r >= 0; r--) begin
      if (i_row[r].en && ((i_u & i_row[r].mask) == (i_row[r].value & i_row[r].mask))) begin
        o_any_hit = 1'b1;
        o_rule    = RW'(r);
        o_sel     = i_row[r];
      end
    end
  end

endmodule

// File: rtl/prog_automata.sv
// Table-driven Mealy engine: per-state prioritised product-term rules pick next state and registered C.
// One register stage from U to state/C/hit; the table is writable only while run=0.
module prog_automata
  import automata_pkg::*;
#(
  parameter int U_W         = PKG_U_W,
  parameter int C_W         = PKG_C_W,
  parameter int N_STATES    = PKG_N_STATES,
  parameter int RULES       = PKG_RULES,
  parameter int RESET_STATE = 0,
  localparam int SW         = width_of(N_STATES),
  localparam int RW         = width_of(RULES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [U_W-1:0] U,
  output logic [C_W-1:0] C,
  output logic [SW-1:0]  state,
  output logic           hit,
  output logic [RW-1:0]  hit_rule,
  input  logic           cfg_we,
  input  logic           cfg_dflt,
  input  logic [SW-1:0]  cfg_state,
  input  logic [RW-1:0]  cfg_rule,
  input  logic           cfg_en,
  input  logic [U_W-1:0] cfg_mask,
  input  logic [U_W-1:0] cfg_value,
  input  logic [SW-1:0]  cfg_next,
  input  logic [C_W-1:0] cfg_out,
  output logic           cfg_err
);

  if (RESET_STATE < 0 || RESET_STATE >= N_STATES) begin : g_bad_reset_state
    $fatal(1, "prog_automata: RESET_STATE out of range");
  end
  if (N_STATES < 2 || RULES < 2 || U_W != PKG_U_W || C_W != PKG_C_W || SW != PKG_SW) begin : g_bad_widths
    $fatal(1, "prog_automata: parameters incompatible with automata_pkg widths");
  end

  rule_t           r_rules [N_STATES][RULES];
  dflt_t           r_dflt  [N_STATES];
  logic [SW-1:0]   r_state;
  logic [C_W-1:0]  r_c;
  logic            r_hit;
  logic [RW-1:0]   r_hit_rule;
  logic            r_cfg_err;

  rule_t           w_row [RULES];
  rule_t           w_sel;
  dflt_t           w_dflt;
  logic            w_any_hit;
  logic [RW-1:0]   w_rule;
  logic            w_cfg_valid;
  logic            w_cfg_accept;
  logic [SW-1:0]   w_state_nxt;
  logic [C_W-1:0]  w_c_nxt;
  logic            w_hit_nxt;
  logic [RW-1:0]   w_hit_rule_nxt;

  assign w_row  = r_rules[r_state];
  assign w_dflt = r_dflt[r_state];

  automata_rule_match #(.RULES(RULES), .RW(RW)) u_match (
    .i_u       (U),
    .i_row     (w_row),
    .o_any_hit (w_any_hit),
    .o_rule    (w_rule),
    .o_sel     (w_sel)
  );

  // Range checks on the write indices keep the state register inside N_STATES.
  assign w_cfg_valid  = !run && in_range(32'(cfg_state), N_STATES)
                        && (cfg_dflt || in_range(32'(cfg_next), N_STATES));
  assign w_cfg_accept = cfg_we && w_cfg_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STATES; s++) begin
        for (int r = 0; r < RULES; r++) r_rules[s][r] <= '0;
        r_dflt[s] <= '{en: 1'b1, out: '0};
      end
    end else if (w_cfg_accept) begin
      if (cfg_dflt)
        r_dflt[cfg_state] <= '{en: cfg_en, out: cfg_out};
      else if (in_range(32'(cfg_rule), RULES))
        r_rules[cfg_state][cfg_rule] <= '{en: cfg_en, mask: cfg_mask, value: cfg_value,
                                          next: cfg_next, out: cfg_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SW'(RESET_STATE);
      r_c        <= '0;
      r_hit      <= 1'b0;
      r_hit_rule <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_c        <= w_c_nxt;
      r_hit      <= w_hit_nxt;
      r_hit_rule <= w_hit_rule_nxt;
      r_cfg_err  <= cfg_we && !w_cfg_valid;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_c_nxt        = r_c;
    w_hit_nxt      = r_hit;
    w_hit_rule_nxt = r_hit_rule;
    if (run) begin
      if (w_any_hit) begin
        w_state_nxt    = w_sel.next;
        w_c_nxt        = w_sel.out;
        w_hit_nxt      = 1'b1;
        w_hit_rule_nxt = w_rule;
      end else begin
        w_hit_nxt = 1'b0;
        if (w_dflt.en) w_c_nxt = w_dflt.out;
      end
    end
  end

  always_comb begin
    state    = r_state;
    C        = r_c;
    hit      = r_hit;
    hit_rule = r_hit_rule;
    cfg_err  = r_cfg_err;
  end

endmodule

// File: tb/tb_prog_automata.sv
// Directed bench for prog_automata; N_STATES=6 so out-of-range state/next indices are encodable.
module tb_prog_automata;

  localparam int NS = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] U;
  logic [7:0] C;
  logic [2:0] state;
  logic       hit;
  logic [1:0] hit_rule;
  logic       cfg_we, cfg_dflt, cfg_en;
  logic [2:0] cfg_state, cfg_next;
  logic [1:0] cfg_rule;
  logic [7:0] cfg_mask, cfg_value, cfg_out;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_automata #(.U_W(8), .C_W(8), .N_STATES(NS), .RULES(4), .RESET_STATE(0)) dut (
    .clk(clk), .rst(rst), .run(run), .U(U), .C(C), .state(state), .hit(hit),
    .hit_rule(hit_rule), .cfg_we(cfg_we), .cfg_dflt(cfg_dflt), .cfg_state(cfg_state),
    .cfg_rule(cfg_rule), .cfg_en(cfg_en), .cfg_mask(cfg_mask), .cfg_value(cfg_value),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .cfg_err(cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic d, input logic [2:0] st, input logic [1:0] rl,
                           input logic en, input logic [7:0] m, input logic [7:0] v,
                           input logic [2:0] nx, input logic [7:0] o);
    cfg_dflt = d; cfg_state = st; cfg_rule = rl; cfg_en = en;
    cfg_mask = m; cfg_value = v; cfg_next = nx; cfg_out = o;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [7:0] c,
                         input logic h);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_C"},     32'(C),     32'(c));
    chk({tag, "_hit"},   32'(hit),   32'(h));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; U = 8'h00;
    cfg_we = 1'b0; cfg_dflt = 1'b0; cfg_state = '0; cfg_rule = '0; cfg_en = 1'b0;
    cfg_mask = '0; cfg_value = '0; cfg_next = '0; cfg_out = '0;
    tick(); tick();
    chk_out("reset", 3'd0, 8'h00, 1'b0);
    chk("reset_hit_rule", 32'(hit_rule), 32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);

    rst = 1'b0;
    cfg_write(1'b0, 3'd0, 2'd0, 1'b1, 8'h03, 8'h00, 3'd2, 8'h83);
    chk("load_s0r0_err", 32'(cfg_err), 32'd0);
    cfg_write(1'b0, 3'd2, 2'd0, 1'b1, 8'h08, 8'h08, 3'd2, 8'h84);
    cfg_write(1'b0, 3'd2, 2'd1, 1'b1, 8'h00, 8'h00, 3'd1, 8'hF5);
    chk("load_s2r1_err", 32'(cfg_err), 32'd0);

    // Masked match: FC & 03 == 00
    run = 1'b1; U = 8'hFC;
    tick();
    chk_out("s0_step", 3'd2, 8'h83, 1'b1);
    chk("s0_step_rule", 32'(hit_rule), 32'd0);

    // Both rules match: lower index wins
    U = 8'h08;
    tick();
    chk_out("prio_r0", 3'd2, 8'h84, 1'b1);
    chk("prio_r0_rule", 32'(hit_rule), 32'd0);

    U = 8'h00;
    tick();
    chk_out("wild_r1", 3'd1, 8'hF5, 1'b1);
    chk("wild_r1_rule", 32'(hit_rule), 32'd1);

    // Default disabled: C holds F5
    run = 1'b0;
    cfg_write(1'b1, 3'd1, 2'd0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h55);
    run = 1'b1;
    tick();
    chk_out("dflt_off", 3'd1, 8'hF5, 1'b0);
    chk("dflt_off_rule_hold", 32'(hit_rule), 32'd1);

    run = 1'b0;
    cfg_write(1'b1, 3'd1, 2'd0, 1'b1, 8'h00, 8'h00, 3'd0, 8'h00);
    run = 1'b1;
    tick();
    chk_out("dflt_on", 3'd1, 8'h00, 1'b0);
    chk("dflt_on_rule_hold", 32'(hit_rule), 32'd1);

    // Write during run: rejected, step still happens
    cfg_write(1'b0, 3'd1, 2'd0, 1'b1, 8'h00, 8'h00, 3'd3, 8'hAE);
    chk("run_we_err", 32'(cfg_err), 32'd1);
    chk_out("run_we_step", 3'd1, 8'h00, 1'b0);
    tick();
    chk("run_we_err_clear", 32'(cfg_err), 32'd0);
    chk_out("run_we_unchanged", 3'd1, 8'h00, 1'b0);

    run = 1'b0;
    cfg_write(1'b0, 3'd1, 2'd0, 1'b1, 8'h00, 8'h00, 3'(NS), 8'hAE);
    chk("bad_next_err", 32'(cfg_err), 32'd1);
    cfg_write(1'b0, 3'(NS), 2'd0, 1'b1, 8'h00, 8'h00, 3'd3, 8'hAE);
    chk("bad_state_err", 32'(cfg_err), 32'd1);
    tick();
    chk("bad_err_clear", 32'(cfg_err), 32'd0);
    run = 1'b1;
    tick();
    chk_out("bad_unchanged", 3'd1, 8'h00, 1'b0);

    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      U = i[0] ? 8'hFF : 8'h00;
      tick();
      chk_out("halt", 3'd1, 8'h00, 1'b0);
      chk("halt_rule", 32'(hit_rule), 32'd1);
    end

    cfg_write(1'b0, 3'd1, 2'd0, 1'b1, 8'h00, 8'h00, 3'd3, 8'hAE);
    chk("good_write_err", 32'(cfg_err), 32'd0);
    run = 1'b1; U = 8'h5A;
    tick();
    chk_out("to_s3", 3'd3, 8'hAE, 1'b1);
    chk("to_s3_rule", 32'(hit_rule), 32'd0);

    // Reset wins over run
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 3'd0, 8'h00, 1'b0);
    chk("mid_rst_rule", 32'(hit_rule), 32'd0);
    rst = 1'b0; U = 8'hFC;
    tick();
    chk_out("post_rst_nomatch", 3'd0, 8'h00, 1'b0);
    U = 8'h00;
    tick();
    chk_out("post_rst_nomatch2", 3'd0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
